// File: rtl/mem_burst_reader.sv
// Burst reader: streams consecutive words from a synchronous memory onto a
// valid/ready port through a small credit-managed output FIFO.
//
// state   | meaning
// --------+---------------------------------------------------------
// S_IDLE  | waiting for start
// S_RUN   | issuing reads while FIFO credit allows
// S_DRAIN | all reads issued, emptying FIFO to the consumer
// S_DONE  | one-cycle done pulse, then back to idle
module mem_burst_reader #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int LEN_W      = 11,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  length,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    issue_rem_q, issue_rem_d;
    logic [LEN_W-1:0]    pop_rem_q, pop_rem_d;
    logic                inflight_q, inflight_d;
    logic [DATA_W-1:0]   fifo_mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0]   fifo_mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    fifo_count_q, fifo_count_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                pop;
    logic [CNT_W-1:0]    occ_next;

    assign out_valid = (fifo_count_q != '0);
    assign out_data  = fifo_mem_q[rd_ptr_q];
    assign out_last  = out_valid && (pop_rem_q == LEN_W'(1));
    assign pop       = out_valid && out_ready;
    assign busy      = busy_q;
    assign done      = done_q;
    assign mem_addr  = addr_q;

    // Credit: entries held plus the read in flight, minus this cycle's pop.
    assign occ_next  = fifo_count_q + CNT_W'(inflight_q) - CNT_W'(pop);
    assign mem_rd_en = (state_q == S_RUN) && (issue_rem_q != '0)
                       && (occ_next < CNT_W'(FIFO_DEPTH));

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        issue_rem_d  = issue_rem_q;
        pop_rem_d    = pop_rem_q;
        inflight_d   = mem_rd_en;
        fifo_mem_d   = fifo_mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fifo_count_d = occ_next;

        if (inflight_q) begin
            fifo_mem_d[wr_ptr_q] = mem_rd_data;
            wr_ptr_d             = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d  = rd_ptr_q + 1'b1;
            pop_rem_d = pop_rem_q - 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        state_d     = S_RUN;
                        addr_d      = start_addr;
                        issue_rem_d = length;
                        pop_rem_d   = length;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_RUN: begin
                if (mem_rd_en) begin
                    addr_d      = addr_q + 1'b1;
                    issue_rem_d = issue_rem_q - 1'b1;
                    if (issue_rem_q == LEN_W'(1)) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pop && (pop_rem_q == LEN_W'(1))) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Abort wins over everything: a read already issued is simply never captured.
        if (abort && (state_q != S_IDLE)) begin
            state_d      = S_IDLE;
            inflight_d   = 1'b0;
            fifo_count_d = '0;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            issue_rem_d  = '0;
            pop_rem_d    = '0;
        end

        busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            issue_rem_q  <= '0;
            pop_rem_q    <= '0;
            inflight_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            issue_rem_q  <= issue_rem_d;
            pop_rem_q    <= pop_rem_d;
            inflight_q   <= inflight_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_count_q <= fifo_count_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            fifo_mem_q   <= fifo_mem_d;
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n)
        !(inflight_q && !pop && (fifo_count_q == CNT_W'(FIFO_DEPTH))));

endmodule
